// File: rtl/data_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : data_mem_ctrl                                                 |
// | Purpose  : Memory-stage data controller. Stores are posted into a FIFO   |
// |            write buffer that drains to a single-port synchronous SRAM.   |
// |            Loads run through an FSM that covers the SRAM read latency.   |
// |            Optional macro WBUF_FORWARD_EN: loads that hit a buffered     |
// |            store are answered from the buffer in the same cycle.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module data_mem_ctrl #(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_BITS  = 8,
  parameter int WBUF_DEPTH = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic [WORD_SIZE-1:0]        DataAddr,
  input  logic [WORD_SIZE-1:0]        DataOut,
  input  logic                        ReadData,
  input  logic                        WriteData,
  output logic [WORD_SIZE-1:0]        DataIn,
  output logic                        DataWaitreq,
  output logic [ADDR_BITS-1:0]        mem_addr,
  output logic [WORD_SIZE-1:0]        mem_wdata,
  output logic                        mem_we,
  output logic                        mem_re,
  input  logic [WORD_SIZE-1:0]        mem_rdata,
  output logic [$clog2(WBUF_DEPTH):0] wbuf_count
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = $clog2(RD_LATENCY + 1);

  localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(WBUF_DEPTH);
  localparam logic [LAT_W-1:0] c_LAT_INIT = LAT_W'(RD_LATENCY - 1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_DRAIN = 3'd1;
  localparam logic [2:0] c_ISSUE = 3'd2;
  localparam logic [2:0] c_WAIT  = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  logic [ADDR_BITS-1:0] wb_addr_q [WBUF_DEPTH];
  logic [WORD_SIZE-1:0] wb_data_q [WBUF_DEPTH];
  logic [PTR_W-1:0]     head_q, tail_q;
  logic [CNT_W-1:0]     count_q;
  logic [2:0]           state_q, state_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;

  logic [ADDR_BITS-1:0] w_req_addr;
  logic                 w_wr_req, w_rd_req, w_full, w_push, w_pop;
  logic                 w_fwd_hit;
  logic [WORD_SIZE-1:0] w_fwd_data;

  // Only the low address bits reach the SRAM; the rest are intentionally dropped.
  if (WORD_SIZE > ADDR_BITS) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^DataAddr[WORD_SIZE-1:ADDR_BITS];
  end

  assign w_req_addr = DataAddr[ADDR_BITS-1:0];
  assign w_wr_req   = WriteData;               // write wins when both are high
  assign w_rd_req   = ReadData & ~WriteData;
  assign w_full     = (count_q == c_FULL_CNT);
  assign w_push     = w_wr_req & ~w_full & (state_q == c_IDLE);
  // The SRAM port belongs to the read in ISSUE; Reset blocks the drain so
  // pending writes are discarded rather than leaking out.
  assign w_pop      = (count_q != '0) & (state_q != c_ISSUE) & ~Reset;

`ifdef WBUF_FORWARD_EN
  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      if ((CNT_W'(k) < count_q) &&
          (wb_addr_q[head_q + PTR_W'(k)] == w_req_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = wb_data_q[head_q + PTR_W'(k)];
      end
    end
  end
`else
  assign w_fwd_hit  = 1'b0;
  assign w_fwd_data = '0;
`endif

  // Buffer pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (w_push) tail_q <= tail_q + 1'b1;
      if (w_pop)  head_q <= head_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Buffer storage: data path only, validity is tracked by the pointers.
  always_ff @(posedge Clock) begin
    if (w_push) begin
      wb_addr_q[tail_q] <= w_req_addr;
      wb_data_q[tail_q] <= DataOut;
    end
  end

  // Read FSM next-state, latency countdown and read-data capture.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    rdata_d = rdata_q;
    case (state_q)
      c_IDLE: begin
        if (w_rd_req && !w_fwd_hit) begin
`ifdef WBUF_FORWARD_EN
          state_d = c_ISSUE;  // no address match, so reordering is safe
`else
          state_d = (count_q != '0) ? c_DRAIN : c_ISSUE;
`endif
        end
      end
      c_DRAIN: begin
        if (count_q == '0) state_d = c_ISSUE;
      end
      c_ISSUE: begin
        state_d = c_WAIT;
        lat_d   = c_LAT_INIT;
      end
      c_WAIT: begin
        if (lat_q == '0) begin
          rdata_d = mem_rdata;
          state_d = c_DONE;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      c_DONE:  state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // FSM state registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= c_IDLE;
      lat_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_d;
    end
  end

  // Stall the Memory stage until the store is accepted or load data is ready.
  always_comb begin
    DataWaitreq = 1'b0;
    case (state_q)
      c_IDLE: begin
        if (w_wr_req)      DataWaitreq = w_full;
        else if (w_rd_req) DataWaitreq = ~w_fwd_hit;
      end
      c_DRAIN, c_ISSUE, c_WAIT: DataWaitreq = 1'b1;
      default: DataWaitreq = 1'b0;
    endcase
  end

  assign DataIn     = (state_q == c_DONE) ? rdata_q :
                      ((state_q == c_IDLE) && w_rd_req && w_fwd_hit) ? w_fwd_data : '0;
  assign mem_re     = (state_q == c_ISSUE) & ~Reset;
  assign mem_we     = w_pop;
  assign mem_addr   = (state_q == c_ISSUE) ? w_req_addr : wb_addr_q[head_q];
  assign mem_wdata  = wb_data_q[head_q];
  assign wbuf_count = count_q;

endmodule
`default_nettype wire
